shift_controller: RTL

- Sequencing controller for the 8-bit barrel shifter (VALUE/OFFSET/SHIFT_BIT/DIRECTION interface, combinational with per-stage delay).
- Accepts a shift request from the ALU/control path with a START/BUSY/DONE handshake and drives the shifter's inputs.
- Waits a programmable settle time, then samples the shifter's output.
- Adds ASR and ROR on top of the shifter's logical shifts: ROR uses two shifter passes, then an OR.

---
 rtl/shift_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/shift_controller.sv
// Sequencing controller for the 8-bit barrel shifter: START/BUSY/DONE handshake, settle-timed
// sampling, ASR and two-pass ROR. Optional Z/C flags are enabled by SHIFT_CTRL_FLAGS_EN.
module shift_controller #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [1:0] opcode_i,
  input  logic [7:0] operand_i,
  input  logic [7:0] amount_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] result_o,
  output logic [7:0] sh_value_o,
  output logic [7:0] sh_offset_o,
  output logic       sh_shift_bit_o,
  output logic       sh_direction_o,
`ifdef SHIFT_CTRL_FLAGS_EN
  output logic       z_flag_o,
  output logic       c_flag_o,
`endif
  input  logic [7:0] sh_result_i
);

  localparam logic [1:0] OpLsl = 2'b00;
  localparam logic [1:0] OpAsr = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] amount_q, amount_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] partial_q, partial_d;
  logic [7:0] result_q, result_d;
  logic       load_result;
  logic [2:0] ror_n;

  function automatic logic is_bypass(input logic [1:0] op, input logic [7:0] amt);
    return (amt == 8'd0) || ((op == OpRor) && (amt[2:0] == 3'd0));
  endfunction

  assign ror_n = amount_q[2:0];

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    operand_d      = operand_q;
    amount_d       = amount_q;
    cnt_d          = cnt_q;
    partial_d      = partial_q;
    result_d       = result_q;
    load_result    = 1'b0;
    sh_value_o     = 8'd0;
    sh_offset_o    = 8'd0;
    sh_shift_bit_o = 1'b0;
    sh_direction_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          opcode_d  = opcode_i;
          operand_d = operand_i;
          amount_d  = amount_i;
          if (is_bypass(opcode_i, amount_i)) begin
            result_d    = operand_i;
            load_result = 1'b1;
            state_d     = StDone;
          end else begin
            cnt_d   = SettleLoad;
            state_d = StPass1;
          end
        end
      end
      StPass1: begin
        // ROR pass 1 is a logical right shift by the low three amount bits
        sh_value_o     = operand_q;
        sh_direction_o = (opcode_q != OpLsl);
        sh_shift_bit_o = (opcode_q == OpAsr) & operand_q[7];
        sh_offset_o    = (opcode_q == OpRor) ? {5'd0, ror_n} : amount_q;
        if (cnt_q == 4'd1) begin
          if (opcode_q == OpRor) begin
            partial_d = sh_result_i;
            cnt_d     = SettleLoad;
            state_d   = StPass2;
          end else begin
            result_d    = sh_result_i;
            load_result = 1'b1;
            state_d     = StDone;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StPass2: begin
        sh_value_o  = operand_q;
        sh_offset_o = 8'd8 - {5'd0, ror_n};
        if (cnt_q == 4'd1) begin
          result_d    = partial_q | sh_result_i;
          load_result = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      opcode_q  <= 2'd0;
      operand_q <= 8'd0;
      amount_q  <= 8'd0;
      cnt_q     <= 4'd0;
      partial_q <= 8'd0;
      result_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      amount_q  <= amount_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;

`ifdef SHIFT_CTRL_FLAGS_EN
  logic       z_flag_q, c_flag_q;
  logic [1:0] fl_op;
  logic [7:0] fl_operand, fl_amount;

  function automatic logic calc_carry(input logic [1:0] op, input logic [7:0] a,
                                      input logic [7:0] amt, input logic [7:0] res);
    logic c;
    c = 1'b0;
    if (amt != 8'd0) begin
      unique case (op)
        2'b00:   c = (amt >= 8'd8) ? 1'b0 : a[3'(4'd8 - {1'b0, amt[2:0]})];
        2'b01:   c = (amt >= 8'd8) ? 1'b0 : a[amt[2:0] - 3'd1];
        2'b10:   c = (amt >= 8'd8) ? a[7] : a[amt[2:0] - 3'd1];
        default: c = res[7];
      endcase
    end
    return c;
  endfunction

  // A bypass op completes on the accept edge, before the operands are registered
  assign fl_op      = (state_q == StIdle) ? opcode_i  : opcode_q;
  assign fl_operand = (state_q == StIdle) ? operand_i : operand_q;
  assign fl_amount  = (state_q == StIdle) ? amount_i  : amount_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      z_flag_q <= 1'b0;
      c_flag_q <= 1'b0;
    end else if (load_result) begin
      z_flag_q <= (result_d == 8'd0);
      c_flag_q <= calc_carry(fl_op, fl_operand, fl_amount, result_d);
    end
  end

  assign z_flag_o = z_flag_q;
  assign c_flag_o = c_flag_q;
`endif

endmodule
